// File: rtl/col_stream_scheduler.sv
// Sequences the column-buffer router across an image tile: per-row route enables,
// row-0 start flag and read requests timed so that data returns on each ROUTE cycle.
module col_stream_scheduler #(
  parameter int RowBufSize  = 256,
  parameter int RowBufAddrW = $clog2(RowBufSize),
  parameter int RowCntW     = 10,
  parameter int AddrW       = 16
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   cfg_start,
  input  logic [RowCntW-1:0]     cfg_rows,
  input  logic [RowBufAddrW-1:0] cfg_cols,
  input  logic [AddrW-1:0]       cfg_base,
  input  logic [AddrW-1:0]       cfg_stride,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_rd_en,
  output logic [AddrW-1:0]       mem_addr,
  output logic                   cb_route_en,
  output logic                   cb_start,
  output logic [RowBufAddrW-1:0] cb_col_size,
  input  logic                   cb_row_done
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ROW, NEXT, FIN} state_e;

  state_e                 state_q, state_d;
  logic [RowCntW-1:0]     rows_q, rows_d, row_q, row_d;
  logic [RowBufAddrW-1:0] cols_q, cols_d, col_q, col_d;
  logic [AddrW-1:0]       base_q, base_d, stride_q, stride_d;
  logic                   phase_q, phase_d;

  logic                   busy_q, busy_d, done_q, done_d;
  logic                   rd_q, rd_d, route_q, route_d, start_q, start_d;
  logic [AddrW-1:0]       addr_q, addr_d;

  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    cols_d   = cols_q;
    row_d    = row_q;
    col_d    = col_q;
    base_d   = base_q;
    stride_d = stride_q;
    phase_d  = phase_q;

    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          rows_d   = cfg_rows;
          cols_d   = cfg_cols;
          base_d   = cfg_base;
          stride_d = cfg_stride;
          row_d    = '0;
          col_d    = '0;
          phase_d  = 1'b0;
          state_d  = (cfg_rows == '0 || cfg_cols == '0) ? FIN : NEXT;
        end
      end
      NEXT: begin
        // The column-0 read is presented in this cycle; a single-column row is already fully issued.
        if (row_q < rows_q) begin
          col_d   = '0;
          phase_d = 1'b1;
          state_d = (cols_q == RowBufAddrW'(1)) ? WAIT_ROW : ISSUE;
        end else begin
          state_d = FIN;
        end
      end
      ISSUE: begin
        if (phase_q) begin
          phase_d = 1'b0;
          col_d   = col_q + RowBufAddrW'(1);
        end else if (col_q == cols_q - RowBufAddrW'(1)) begin
          state_d = WAIT_ROW;
        end else begin
          phase_d = 1'b1;
        end
      end
      WAIT_ROW: begin
        if (cb_row_done) begin
          row_d   = row_q + RowCntW'(1);
          base_d  = base_q + stride_q;
          col_d   = '0;
          state_d = (row_q + RowCntW'(1) >= rows_q) ? FIN : NEXT;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered by decoding the next state, so they line up with the state they describe.
  always_comb begin
    route_d = (state_d == NEXT) && (row_d < rows_d);
    rd_d    = route_d || ((state_d == ISSUE) && !phase_d);
    addr_d  = base_d + AddrW'(col_d);
    busy_d  = (state_d != IDLE) && (state_d != FIN);
    done_d  = (state_d == FIN);
    start_d = (row_d == '0) &&
              (state_d == NEXT || state_d == ISSUE || state_d == WAIT_ROW);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= IDLE;
      rows_q   <= '0;
      cols_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      base_q   <= '0;
      stride_q <= '0;
      phase_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_q     <= 1'b0;
      route_q  <= 1'b0;
      start_q  <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      rows_q   <= rows_d;
      cols_q   <= cols_d;
      row_q    <= row_d;
      col_q    <= col_d;
      base_q   <= base_d;
      stride_q <= stride_d;
      phase_q  <= phase_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_q     <= rd_d;
      route_q  <= route_d;
      start_q  <= start_d;
      addr_q   <= addr_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_rd_en   = rd_q;
  assign mem_addr    = addr_q;
  assign cb_route_en = route_q;
  assign cb_start    = start_q;
  assign cb_col_size = cols_q;

endmodule

// File: tb/tb_col_stream_scheduler.sv
// Randomized bench: builds the expected per-cycle timeline of each tile from the
// row/column timing rules and compares every output cycle by cycle.
module tb_col_stream_scheduler;
  localparam int AW = 16;
  localparam int CW = 8;
  localparam int RW = 10;

  logic          clk = 1'b0;
  logic          nrst;
  logic          cfg_start;
  logic [RW-1:0] cfg_rows;
  logic [CW-1:0] cfg_cols;
  logic [AW-1:0] cfg_base, cfg_stride;
  logic          busy, done, mem_rd_en, cb_route_en, cb_start, cb_row_done;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] cb_col_size;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  col_stream_scheduler #(.RowBufSize(256), .RowCntW(RW), .AddrW(AW)) dut (
    .clk(clk), .nrst(nrst), .cfg_start(cfg_start), .cfg_rows(cfg_rows),
    .cfg_cols(cfg_cols), .cfg_base(cfg_base), .cfg_stride(cfg_stride),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .cb_route_en(cb_route_en), .cb_start(cb_start), .cb_col_size(cb_col_size),
    .cb_row_done(cb_row_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic scramble_cfg();
    cfg_rows   = RW'($urandom);
    cfg_cols   = CW'($urandom);
    cfg_base   = AW'($urandom);
    cfg_stride = AW'($urandom);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_busy"},  busy,        0);
    check_eq({tag, "_done"},  done,        0);
    check_eq({tag, "_rd"},    mem_rd_en,   0);
    check_eq({tag, "_route"}, cb_route_en, 0);
    check_eq({tag, "_start"}, cb_start,    0);
  endtask

  // One tile: expected reads, route pulses, row_done arrivals and done derived from the row timing rules.
  task automatic run_cfg(input int rows, input int cols, input logic [AW-1:0] base,
                         input logic [AW-1:0] stride, input int poke);
    int route[$];
    int rdc[$];
    bit exp_rd[int];
    logic [AW-1:0] exp_addr[int];
    int s, t, rd, done_c;
    bit nonzero, in_route, in_rdc;

    step();
    s = cyc;
    cfg_start  = 1'b1;
    cfg_rows   = RW'(rows);
    cfg_cols   = CW'(cols);
    cfg_base   = base;
    cfg_stride = stride;
    nonzero = (rows != 0) && (cols != 0);

    if (!nonzero) begin
      done_c = s + 1;
    end else begin
      t = s + 1;
      for (int r = 0; r < rows; r++) begin
        route.push_back(t);
        for (int k = 0; k < cols; k++) begin
          exp_rd[t + 2 * k]   = 1'b1;
          exp_addr[t + 2 * k] = AW'(int'(base) + r * int'(stride) + k);
        end
        rd = t + 2 * cols + 1 + int'($urandom_range(0, 3));
        rdc.push_back(rd);
        t = rd + 1;
      end
      done_c = rdc[rows - 1] + 1;
    end

    for (int c = s + 1; c <= done_c + 1; c++) begin
      step();
      cfg_start = 1'b0;
      scramble_cfg();
      if (poke != 0 && c == s + poke) cfg_start = 1'b1;

      in_route = 1'b0;
      in_rdc   = 1'b0;
      foreach (route[i]) if (route[i] == c) in_route = 1'b1;
      foreach (rdc[i])   if (rdc[i] == c)   in_rdc   = 1'b1;

      check_eq("rd_en", mem_rd_en, exp_rd.exists(c) ? 1 : 0);
      if (exp_rd.exists(c)) check_eq("addr", mem_addr, exp_addr[c]);
      check_eq("route_en", cb_route_en, in_route);
      check_eq("done", done, c == done_c);
      check_eq("busy", busy, (c > s) && (c < done_c));
      check_eq("cb_start", cb_start, nonzero && (c >= route[0]) && (c <= rdc[0]));
      if (c <= done_c) check_eq("col_size", cb_col_size, cols);

      if (in_route) cb_row_done = 1'b0;
      if (in_rdc)   cb_row_done = 1'b1;
    end
  endtask

  task automatic reset_mid_issue();
    step();
    cfg_start  = 1'b1;
    cfg_rows   = 10'd3;
    cfg_cols   = 8'd4;
    cfg_base   = 16'h2000;
    cfg_stride = 16'h0010;
    step();
    cfg_start = 1'b0;
    scramble_cfg();
    cb_row_done = 1'b0;
    step();
    step();
    check_eq("pre_rst_busy", busy, 1);
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    check_quiet("rst_mid");
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("rst_no_done", done, 0);
      check_eq("rst_idle_busy", busy, 0);
    end
  endtask

  initial begin
    nrst        = 1'b0;
    cfg_start   = 1'b0;
    cb_row_done = 1'b0;
    scramble_cfg();
    for (int i = 0; i < 2; i++) begin
      step();
      cfg_start   = 1'($urandom);
      cb_row_done = 1'($urandom);
      scramble_cfg();
    end
    step();
    check_quiet("reset");
    check_eq("reset_addr", mem_addr, 0);
    check_eq("reset_colsize", cb_col_size, 0);
    nrst        = 1'b1;
    cfg_start   = 1'b0;
    cb_row_done = 1'b0;
    step();

    run_cfg(2, 3, 16'h0100, 16'h0040, 0);
    run_cfg(1, 1, 16'h0ABC, 16'h0000, 0);
    run_cfg(0, 3, 16'h1234, 16'h0010, 0);
    run_cfg(3, 0, 16'h1234, 16'h0010, 0);
    run_cfg(2, 3, 16'h0300, 16'h0040, 3);
    run_cfg(2, 2, 16'hFFF0, 16'h0020, 0);
    reset_mid_issue();
    run_cfg(2, 3, 16'h0100, 16'h0040, 0);

    for (int n = 0; n < 25; n++) begin
      int r, c;
      r = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
      c = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
      run_cfg(r, c, AW'($urandom), AW'($urandom), ($urandom_range(0, 1) == 1) ? 3 : 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
